// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, widths and
// the fixed divide-by-zero quotient.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // Trial subtraction; the extra top bit of diff carries the borrow.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    borrow  = diff[WIDTH+1];
    // The surviving remainder is always below the divisor, so it fits WIDTH bits.
    rem_out = WIDTH'(borrow ? shifted : diff[WIDTH:0]);
    quo_out = {quo_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU. Quotient goes to LO,
// remainder to HI. Optional macro DIV_FAST_ZERO_EN short-circuits requests with
// a zero dividend or divisor straight to DONE.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quo,
  output logic [WIDTH-1:0] out_rem,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZeroQuo = WIDTH'(DIV_ZERO_QUO);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, a_raw_q;
  logic             quo_neg_q, rem_neg_q, b_zero_q;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvs_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  // Operand magnitudes and sign flags; abs(most-negative) stays 2^(WIDTH-1) unsigned.
  always_comb begin
    a_neg = in_signed & in_a[WIDTH-1];
    b_neg = in_signed & in_b[WIDTH-1];
    a_abs = a_neg ? (~in_a + 1'b1) : in_a;
    b_abs = b_neg ? (~in_b + 1'b1) : in_b;
  end

  // Sign correction applied to the result of the final iteration.
  always_comb begin
    quo_fix = quo_neg_q ? (~step_quo + 1'b1) : step_quo;
    rem_fix = rem_neg_q ? (~step_rem + 1'b1) : step_rem;
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CALC) || (state_q == DONE);

  // FSM, iteration counter and registered results; cancel overrides everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      a_raw_q   <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      out_valid <= 1'b0;
      out_quo   <= '0;
      out_rem   <= '0;
    end else if (cancel) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvs_q     <= b_abs;
            a_raw_q   <= in_a;
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            b_zero_q  <= (in_b == '0);
            cnt_q     <= '0;
`ifdef DIV_FAST_ZERO_EN
            if (in_b == '0) begin
              out_quo   <= ZeroQuo;
              out_rem   <= in_a;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else if (in_a == '0) begin
              out_quo   <= '0;
              out_rem   <= '0;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // Divide-by-zero result is fixed and bypasses sign correction.
            out_quo   <= b_zero_q ? ZeroQuo : quo_fix;
            out_rem   <= b_zero_q ? a_raw_q : rem_fix;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
